// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace capture unit: FSM state encoding
// and the packed trace-record width.
package cpu_trace_pkg;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int DEF_PC_W   = 8;
    localparam int DEF_DATA_W = 32;

    // One record holds the PC followed by instr, result, rd1 and rd2.
    localparam int REC_W = DEF_PC_W + 4 * DEF_DATA_W;

    function automatic int rec_width(input int pc_w, input int data_w);
        return pc_w + 4 * data_w;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace record storage: DEPTH x WIDTH.
// One synchronous write port and one asynchronous read port.
// Contents are not reset.
module trace_ram
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = REC_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write one record per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU trace capture unit.
// Behaviour:
//  - Records retired-instruction records into a circular buffer.
//  - Freezes capture after a trigger plus a post-trigger window.
//  - Streams the frozen trace out oldest-first over a valid/ready port.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              trig_pc_en,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic              trig_ext,
    input  logic [AW:0]       post_cnt,
    input  logic              cap_valid,
    input  logic [PC_W-1:0]   cap_pc,
    input  logic [DATA_W-1:0] cap_instr,
    input  logic [DATA_W-1:0] cap_result,
    input  logic [DATA_W-1:0] cap_rd1,
    input  logic [DATA_W-1:0] cap_rd2,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PC_W-1:0]   rd_pc,
    output logic [DATA_W-1:0] rd_instr,
    output logic [DATA_W-1:0] rd_result,
    output logic [DATA_W-1:0] rd_rd1,
    output logic [DATA_W-1:0] rd_rd2,
    output logic              rd_last,
    output logic [1:0]        state_o,
    output logic              triggered,
    output logic [AW:0]       count
);

    localparam int        LP_REC_W   = rec_width(PC_W, DATA_W);
    localparam logic [AW:0] LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_MAXPOST = (AW+1)'(DEPTH - 1);

    trace_state_e r_state;
    trace_state_e w_state_nxt;

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW-1:0] r_remaining;
    logic [AW:0]   r_count;
    logic          r_triggered;

    logic          w_capturing;
    logic          w_write;
    logic          w_pc_hit;
    logic          w_trig;
    logic [AW-1:0] w_post;
    logic          w_rd_valid;
    logic          w_beat;
    logic [AW-1:0] w_wp_nxt;
    logic [AW:0]   w_count_nxt;
    logic          w_enter_done;

    logic [LP_REC_W-1:0] w_wr_rec;
    logic [LP_REC_W-1:0] w_ram_rec;
    logic [LP_REC_W-1:0] w_rd_rec;

    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_write     = cap_valid & w_capturing & ~arm;
    assign w_pc_hit    = trig_pc_en & (cap_pc == trig_pc);
    assign w_trig      = (r_state == ST_ARMED) & cap_valid & (trig_ext | w_pc_hit) & ~arm;

    // Clamp keeps the trigger record inside the buffer.
    assign w_post = (post_cnt > LP_MAXPOST) ? LP_MAXPOST[AW-1:0] : post_cnt[AW-1:0];

    assign w_rd_valid = (r_state == ST_DONE) && (r_count != '0);
    assign w_beat     = w_rd_valid & rd_ready;

    assign w_wp_nxt    = w_write ? (r_wp + AW'(1)) : r_wp;
    assign w_count_nxt = (w_write && (r_count != LP_DEPTH)) ? (r_count + (AW+1)'(1)) : r_count;

    assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

    // Next-state logic; arm overrides everything, including a same-cycle trigger.
    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        w_state_nxt = (w_post == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (cap_valid && (r_remaining == AW'(1))) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_beat && (r_count == (AW+1)'(1))) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, occupancy, post-trigger countdown and trigger flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_triggered <= 1'b0;
        end else if (arm) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_triggered <= 1'b0;
        end else begin
            r_wp    <= w_wp_nxt;
            r_count <= w_count_nxt;
            if (w_trig) begin
                r_triggered <= 1'b1;
                r_remaining <= w_post;
            end else if ((r_state == ST_POST) && cap_valid) begin
                r_remaining <= r_remaining - AW'(1);
            end
            // Oldest entry sits count places behind the post-write pointer;
            // a full buffer (count == DEPTH) aliases to rp == wp.
            if (w_enter_done) begin
                r_rp <= w_wp_nxt - w_count_nxt[AW-1:0];
            end
            if (w_beat) begin
                r_rp    <= r_rp + AW'(1);
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign w_wr_rec = {cap_pc, cap_instr, cap_result, cap_rd1, cap_rd2};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (LP_REC_W),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_write),
        .i_waddr (r_wp),
        .i_wdata (w_wr_rec),
        .i_raddr (r_rp),
        .o_rdata (w_ram_rec)
    );

    assign w_rd_rec = w_rd_valid ? w_ram_rec : '0;
    assign {rd_pc, rd_instr, rd_result, rd_rd1, rd_rd2} = w_rd_rec;

    assign rd_valid  = w_rd_valid;
    assign rd_last   = w_rd_valid && (r_count == (AW+1)'(1));
    assign state_o   = r_state;
    assign triggered = r_triggered;
    assign count     = r_count;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer (DEPTH=8).
// Uses a queue-based reference model.
module tb_cpu_trace_buffer;

    localparam int PC_W   = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm;
    logic              trig_pc_en;
    logic [PC_W-1:0]   trig_pc;
    logic              trig_ext;
    logic [AW:0]       post_cnt;
    logic              cap_valid;
    logic [PC_W-1:0]   cap_pc;
    logic [DATA_W-1:0] cap_instr;
    logic [DATA_W-1:0] cap_result;
    logic [DATA_W-1:0] cap_rd1;
    logic [DATA_W-1:0] cap_rd2;
    logic              rd_valid;
    logic              rd_ready;
    logic [PC_W-1:0]   rd_pc;
    logic [DATA_W-1:0] rd_instr;
    logic [DATA_W-1:0] rd_result;
    logic [DATA_W-1:0] rd_rd1;
    logic [DATA_W-1:0] rd_rd2;
    logic              rd_last;
    logic [1:0]        state_o;
    logic              triggered;
    logic [AW:0]       count;

    always #5 clk = ~clk;

    cpu_trace_buffer #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .trig_pc_en (trig_pc_en),
        .trig_pc    (trig_pc),
        .trig_ext   (trig_ext),
        .post_cnt   (post_cnt),
        .cap_valid  (cap_valid),
        .cap_pc     (cap_pc),
        .cap_instr  (cap_instr),
        .cap_result (cap_result),
        .cap_rd1    (cap_rd1),
        .cap_rd2    (cap_rd2),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_pc      (rd_pc),
        .rd_instr   (rd_instr),
        .rd_result  (rd_result),
        .rd_rd1     (rd_rd1),
        .rd_rd2     (rd_rd2),
        .rd_last    (rd_last),
        .state_o    (state_o),
        .triggered  (triggered),
        .count      (count)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
    } rec_t;

    rec_t m_q[$];
    int   m_state;      // 0 idle, 1 armed, 2 post, 3 done
    bit   m_trig;
    int   m_rem;

    function automatic void model_reset();
        m_q.delete();
        m_state = 0;
        m_trig  = 1'b0;
        m_rem   = 0;
    endfunction

    function automatic void model_push();
        rec_t r;
        r.pc     = cap_pc;
        r.instr  = cap_instr;
        r.result = cap_result;
        r.rd1    = cap_rd1;
        r.rd2    = cap_rd2;
        m_q.push_back(r);
        if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
        end
    endfunction

    // Applies one rising edge using the inputs currently driven.
    function automatic void model_edge();
        bit hit;
        if (arm) begin
            m_q.delete();
            m_state = 1;
            m_trig  = 1'b0;
            m_rem   = 0;
            return;
        end
        case (m_state)
            1: begin
                if (cap_valid) begin
                    model_push();
                    hit = trig_ext || (trig_pc_en && (cap_pc == trig_pc));
                    if (hit) begin
                        m_trig  = 1'b1;
                        m_rem   = (int'(post_cnt) > DEPTH - 1) ? DEPTH - 1 : int'(post_cnt);
                        m_state = (m_rem == 0) ? 3 : 2;
                    end
                end
            end
            2: begin
                if (cap_valid) begin
                    model_push();
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_state = 3;
                end
            end
            3: begin
                if ((m_q.size() > 0) && rd_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_state = 0;
                end
            end
            default: ;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        bit ev;
        ev = (m_state == 3) && (m_q.size() > 0);
        chk({tag, " state"}, 64'(state_o), 64'(m_state));
        chk({tag, " count"}, 64'(count), 64'(m_q.size()));
        chk({tag, " triggered"}, 64'(triggered), 64'(m_trig));
        chk({tag, " rd_valid"}, 64'(rd_valid), 64'(ev));
        chk({tag, " rd_last"}, 64'(rd_last), 64'(ev && (m_q.size() == 1)));
        if (ev) begin
            chk({tag, " rd_pc"}, 64'(rd_pc), 64'(m_q[0].pc));
            chk({tag, " rd_instr"}, 64'(rd_instr), 64'(m_q[0].instr));
            chk({tag, " rd_result"}, 64'(rd_result), 64'(m_q[0].result));
            chk({tag, " rd_rd1"}, 64'(rd_rd1), 64'(m_q[0].rd1));
            chk({tag, " rd_rd2"}, 64'(rd_rd2), 64'(m_q[0].rd2));
        end else begin
            chk({tag, " rd_data_zero"}, {rd_pc, rd_instr[31:0], rd_result[23:0]} , 64'd0);
        end
    endtask

    task automatic set_in(input logic a, input logic cv, input logic tx,
                          input logic [PC_W-1:0] pc, input logic [AW:0] pst, input logic rdy);
        arm        = a;
        cap_valid  = cv;
        trig_ext   = tx;
        cap_pc     = pc;
        post_cnt   = pst;
        rd_ready   = rdy;
        cap_instr  = $urandom;
        cap_result = $urandom;
        cap_rd1    = $urandom;
        cap_rd2    = $urandom;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_all(tag);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic            a;
        logic            cv;
        logic            tx;
        logic [PC_W-1:0] pc;
        logic [AW:0]     pst;
        logic            rdy;
        logic [1:0]      e_state;
        logic [AW:0]     e_count;
        logic            e_valid;
        logic [PC_W-1:0] e_pc;
        logic            e_last;
    } vec_t;

    function automatic vec_t mkv(input logic a, input logic cv, input logic tx,
                                 input logic [PC_W-1:0] pc, input logic [AW:0] pst,
                                 input logic rdy, input logic [1:0] st, input logic [AW:0] cnt,
                                 input logic v, input logic [PC_W-1:0] epc, input logic last);
        vec_t t;
        t.a = a; t.cv = cv; t.tx = tx; t.pc = pc; t.pst = pst; t.rdy = rdy;
        t.e_state = st; t.e_count = cnt; t.e_valid = v; t.e_pc = epc; t.e_last = last;
        return t;
    endfunction

    vec_t tv[11];

    initial begin
        reset      = 1'b0;
        trig_pc_en = 1'b0;
        trig_pc    = '0;
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        reset = 1'b1;

        // ---- async reset mid-ARMED ----
        set_in(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        step("rs_arm");
        for (int i = 1; i <= 5; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 8'(i), 4'd0, 1'b0);
            step("rs_cap");
        end
        chk("rs count before", 64'(count), 64'd5);
        set_in(1'b0, 1'b1, 1'b0, 8'd9, 4'd0, 1'b0);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rs async state", 64'(state_o), 64'd0);
        chk("rs async count", 64'(count), 64'd0);
        chk("rs async valid", 64'(rd_valid), 64'd0);
        step("rs_hold");
        step("rs_hold");
        reset = 1'b1;
        set_in(1'b0, 1'b1, 1'b1, 8'd7, 4'd0, 1'b0);
        step("rs_idle_ignore");
        chk("rs idle count", 64'(count), 64'd0);

        // ---- table: 3 pre, ext trigger, post 2, full readout ----
        tv[0]  = mkv(1, 0, 0, 8'd0, 4'd0, 0, 2'd1, 4'd0, 0, 8'd0, 0);
        tv[1]  = mkv(0, 1, 0, 8'd1, 4'd2, 0, 2'd1, 4'd1, 0, 8'd0, 0);
        tv[2]  = mkv(0, 1, 0, 8'd2, 4'd2, 0, 2'd1, 4'd2, 0, 8'd0, 0);
        tv[3]  = mkv(0, 1, 1, 8'd3, 4'd2, 0, 2'd2, 4'd3, 0, 8'd0, 0);
        tv[4]  = mkv(0, 1, 0, 8'd4, 4'd2, 0, 2'd2, 4'd4, 0, 8'd0, 0);
        tv[5]  = mkv(0, 1, 0, 8'd5, 4'd2, 0, 2'd3, 4'd5, 1, 8'd1, 0);
        tv[6]  = mkv(0, 0, 0, 8'd0, 4'd2, 1, 2'd3, 4'd4, 1, 8'd2, 0);
        tv[7]  = mkv(0, 0, 0, 8'd0, 4'd2, 1, 2'd3, 4'd3, 1, 8'd3, 0);
        tv[8]  = mkv(0, 0, 0, 8'd0, 4'd2, 1, 2'd3, 4'd2, 1, 8'd4, 0);
        tv[9]  = mkv(0, 0, 0, 8'd0, 4'd2, 1, 2'd3, 4'd1, 1, 8'd5, 1);
        tv[10] = mkv(0, 0, 0, 8'd0, 4'd2, 1, 2'd0, 4'd0, 0, 8'd0, 0);
        for (int i = 0; i < 11; i++) begin
            set_in(tv[i].a, tv[i].cv, tv[i].tx, tv[i].pc, tv[i].pst, tv[i].rdy);
            step("tbl");
            chk("tbl state", 64'(state_o), 64'(tv[i].e_state));
            chk("tbl count", 64'(count), 64'(tv[i].e_count));
            chk("tbl valid", 64'(rd_valid), 64'(tv[i].e_valid));
            chk("tbl pc", 64'(rd_pc), 64'(tv[i].e_pc));
            chk("tbl last", 64'(rd_last), 64'(tv[i].e_last));
        end
        chk("tbl triggered kept", 64'(triggered), 64'd1);

        // ---- wrap + PC-match trigger, post 0 ----
        trig_pc_en = 1'b1;
        trig_pc    = 8'd12;
        set_in(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        step("wrap_arm");
        for (int p = 0; p <= 12; p++) begin
            set_in(1'b0, 1'b1, 1'b0, 8'(p), 4'd0, 1'b0);
            step("wrap_cap");
        end
        chk("wrap state", 64'(state_o), 64'd3);
        chk("wrap count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap pc", 64'(rd_pc), 64'(5 + i));
            chk("wrap last", 64'(rd_last), 64'(i == 7));
            set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1);
            step("wrap_rd");
        end
        chk("wrap idle", 64'(state_o), 64'd0);
        trig_pc_en = 1'b0;

        // ---- backpressure ----
        set_in(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        step("bp_arm");
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, (i == 2), 8'(20 + i), 4'd0, 1'b0);
            step("bp_cap");
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
            step("bp_hold");
            chk("bp valid", 64'(rd_valid), 64'd1);
            chk("bp pc", 64'(rd_pc), 64'd20);
        end
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1);
        step("bp_pulse");
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        step("bp_after");
        chk("bp one beat pc", 64'(rd_pc), 64'd21);
        chk("bp one beat count", 64'(count), 64'd2);
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1);
        step("bp_drain");
        step("bp_drain");
        chk("bp idle", 64'(state_o), 64'd0);

        // ---- post_cnt clamp ----
        set_in(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        step("cl_arm");
        set_in(1'b0, 1'b1, 1'b1, 8'd100, 4'd15, 1'b0);
        step("cl_trig");
        for (int i = 1; i <= 10; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 8'(100 + i), 4'd15, 1'b0);
            step("cl_post");
        end
        chk("clamp count", 64'(count), 64'd8);
        chk("clamp first pc", 64'(rd_pc), 64'd100);
        for (int i = 0; i < 8; i++) begin
            chk("clamp pc", 64'(rd_pc), 64'(100 + i));
            set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1);
            step("cl_rd");
        end

        // ---- arm during readout, with same-cycle trigger ----
        set_in(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        step("ar_arm");
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 1'b1, (i == 0), 8'(40 + i), 4'd5, 1'b0);
            step("ar_cap");
        end
        chk("ar done count", 64'(count), 64'd6);
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1);
        step("ar_rd");
        step("ar_rd");
        set_in(1'b1, 1'b1, 1'b1, 8'd50, 4'd0, 1'b1);
        step("ar_rearm");
        chk("ar state", 64'(state_o), 64'd1);
        chk("ar count", 64'(count), 64'd0);
        chk("ar trig", 64'(triggered), 64'd0);
        chk("ar valid", 64'(rd_valid), 64'd0);
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        step("ar_after");

        // ---- randomized against the model ----
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) begin
                trig_pc_en = 1'($urandom_range(0, 1));
                trig_pc    = 8'($urandom_range(0, 15));
            end
            set_in(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised on-chip trace capture unit for the RISC core, the synthesizable successor to the monitor-style debug taps (PC, instruction, ALU result, register read values). Records one retired-instruction record per capture strobe into a circular buffer with a configurable PC or external trigger and a post-trigger window. The frozen trace is then streamed out oldest-first over a valid/ready port. Sits beside cpu_top and is fed by its debug outputs.

Parameters:
PC_W, 8, width of program counter field
DATA_W, 32, width of instruction, result, read1, read2 fields
DEPTH, 16, buffer entries; power of two, >= 4
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
arm  in  1  pulse; clear buffer and enter ARMED
trig_pc_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  trigger PC value
trig_ext  in  1  external trigger, sampled with cap_valid
post_cnt  in  AW+1  records to capture after trigger record (0..DEPTH-1)
cap_valid  in  1  capture strobe, one record per cycle high
cap_pc  in  PC_W  record PC
cap_instr  in  DATA_W  record instruction
cap_result  in  DATA_W  record ALU result
cap_rd1  in  DATA_W  record read value 1
cap_rd2  in  DATA_W  record read value 2
rd_valid  out  1  readout record valid
rd_ready  in  1  readout consumer ready
rd_pc, rd_instr, rd_result, rd_rd1, rd_rd2  out  PC_W/DATA_W  readout record fields
rd_last  out  1  current readout record is final
state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
triggered  out  1  trigger seen since last arm
count  out  AW+1  valid entries held (0..DEPTH)

Behaviour:
- Reset (reset=0, async): state IDLE; wp, rp, count, remaining, triggered = 0; rd_valid=0, rd_last=0; data outputs 0. Buffer contents need not be cleared.
- IDLE: ignores cap_valid. arm -> ARMED.
- ARMED: each cap_valid writes mem[wp] on that edge, wp++ (wraps mod DEPTH), count saturates at DEPTH, and oldest entry is overwritten when full.
- Trigger condition: cap_valid & (trig_ext | (trig_pc_en & cap_pc==trig_pc)), evaluated only in ARMED. The triggering record is written. Sets triggered=1 and remaining=min(post_cnt, DEPTH-1). If remaining==0 -> DONE, else -> POST.
- POST: each cap_valid writes and decrements remaining. The write that takes remaining to 0 moves to DONE next cycle. Triggers are ignored.
- DONE: capture frozen (cap_valid ignored). rp = wp - count (mod DEPTH) loaded on entry. rd_valid=1 while unread entries exist. rd_* are driven from mem[rp] and held stable while rd_valid & !rd_ready.
- Readout handshake: a beat transfers on rd_valid & rd_ready; then rp++ and count--. rd_last=1 when count==1. After the last beat: rd_valid=0 next cycle, state -> IDLE, triggered stays 1 until next arm.
- arm in any state, including mid-POST or mid-readout: next cycle state ARMED, wp=rp=count=0, triggered=0, rd_valid=0. arm takes priority over a same-cycle trigger or cap_valid, and that sample is dropped.
- post_cnt > DEPTH-1 clamps to DEPTH-1 so the trigger record is always retained.
- Latency: state_o/triggered/count update on the edge after the causing input; the first rd_valid is in the first DONE cycle.

Decomposition:
- Package cpu_trace_pkg: state encoding constants (ST_IDLE..ST_DONE) and record width localparam REC_W = PC_W + 4*DATA_W.
- One sub-module: trace_ram (DEPTH x REC_W, one write port and one asynchronous read port). Records are packed/unpacked in the top module.

Test Plan:
- Reset mid-ARMED with 5 records written -> state_o=0, count=0, rd_valid=0 immediately (async), no writes while reset=0.
- DEPTH=8, arm, 3 records PC=1,2,3, trig_ext on PC=3, post_cnt=2, PCs 4,5 -> DONE; readout yields PC 1,2,3,4,5 with rd_last only on PC=5; count 5->0; state returns IDLE.
- Wrap: DEPTH=8, 12 records PC=0..11 untriggered, then PC-match trigger trig_pc=12, post_cnt=0 -> count=8, readout PC 5..12 in order.
- Backpressure: in DONE hold rd_ready=0 for 4 cycles -> rd_valid=1 and rd_pc stable; pulse rd_ready for one cycle -> exactly one beat advances.
- post_cnt=15 with DEPTH=8 -> clamped to 7; trigger record at the oldest position is still read out first of 8.
- arm asserted during readout after 2 of 6 beats -> next cycle rd_valid=0, state ARMED, count=0, triggered=0. A same-cycle trig_ext with arm is ignored.
